instr_fetch: RTL and testbench

- Fetch stage directly upstream of the control unit: owns the PC and issues in-order word requests to instruction memory (valid/ready request channel, in-order response channel with latency >=1).
- Buffers returned words in a small prefetch FIFO and presents instr/instr_pc to decode with a valid/ready handshake.
- Accepts redirects (taken branch/jump, driven from the control unit's PCsrc path): flushes buffered words and discards responses still in flight.

---
 rtl/instr_fetch.sv | 169 ++++++++++++++++
 tb/tb_instr_fetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, in-order imem requests, prefetch FIFO, redirect flush
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_flushes counters.
`timescale 1ns/1ps
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [15:0] perf_flushes
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C1 = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [31:0]     r_data   [FIFO_DEPTH];
  logic [31:0]     r_pc_tag [FIFO_DEPTH];

  logic            w_redirect;
  logic [31:0]     w_redirect_tgt;
  logic [CW:0]     w_credit_sum;
  logic            w_accept;
  logic            w_rsp_drop;
  logic            w_rsp_take;
  logic            w_rsp_match;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic [31:0]     w_rsp_pc;
  logic [CW-1:0]   w_drop_redirect;
  logic [CW-1:0]   w_drop_nxt;
  logic [CW-1:0]   w_outstanding_nxt;

  assign w_redirect     = redirect && (r_state != S_IDLE);
  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  assign w_credit_sum   = {1'b0, r_outstanding} + {1'b0, r_count};
  assign imem_req_valid = (r_state == S_RUN) && (w_credit_sum < DEPTH_C1);
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // Responses with neither a pending drop nor a matching request are ignored.
  assign w_rsp_drop  = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_take  = imem_rsp_valid && (r_drop_cnt == '0) && (r_outstanding != '0);
  assign w_rsp_match = w_rsp_drop || w_rsp_take;

  // Outstanding requests are consecutive words, so the oldest one sits behind fetch_pc.
  assign w_rsp_pc = r_fetch_pc - {{(30-CW){1'b0}}, r_outstanding, 2'b00};

  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_data[r_rptr]   : 32'h0;
  assign instr_pc    = instr_valid ? r_pc_tag[r_rptr] : 32'h0;

  assign w_full = (r_count == DEPTH_C);
  assign w_pop  = instr_valid && instr_ready && !w_redirect;
  assign w_push = w_rsp_take && !w_redirect && (!w_full || w_pop);

  assign w_drop_redirect = r_drop_cnt + r_outstanding + CW'(w_accept) - CW'(w_rsp_match);
  assign w_drop_nxt      = w_redirect ? w_drop_redirect : (r_drop_cnt - CW'(w_rsp_drop));
  assign w_outstanding_nxt = w_redirect ? '0
                           : (r_outstanding + CW'(w_accept) - CW'(w_rsp_take));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:         w_state_nxt = S_RUN;
      S_RUN, S_FLUSH: w_state_nxt = (w_drop_nxt != '0) ? S_FLUSH : S_RUN;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_nxt;
      if (redirect) begin
        r_fetch_pc <= w_redirect_tgt;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i]   <= 32'h0;
        r_pc_tag[i] <= 32'h0;
      end
    end else if (w_redirect) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr]   <= imem_rsp_data;
        r_pc_tag[r_wptr] <= w_rsp_pc;
        r_wptr           <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [15:0] r_perf_flushes;
  logic        w_flush_event;

  // A flush counts only if it actually throws away a buffered word or an in-flight request.
  assign w_flush_event = w_redirect && ((r_count != '0) || (r_outstanding != '0) || w_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'h0;
      r_perf_flushes <= 16'h0;
    end else begin
      if (w_pop && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_flush_event && (r_perf_flushes != 16'hFFFF)) begin
        r_perf_flushes <= r_perf_flushes + 16'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a queue-based model
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_flushes;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } word_t;
  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  word_t   m_fifo[$];
  flight_t m_fl[$];
  mreq_t   mem_q[$];
  logic [31:0] m_pc;
  int m_phase, cyc, last_due;
  int checks, errors;
  int lat, p_ready, p_iready, p_redirect;
  bit force_rd, spur;
  logic [31:0] force_pc;
  bit o_rv, o_iv, o_acc;
  logic [31:0] o_ra, o_ipc, o_instr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit any_stale();
    foreach (m_fl[i]) if (m_fl[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_req_valid();
    return (m_phase == 1) && !any_stale() && ((m_fl.size() + m_fifo.size()) < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_chk(input string name, input bit expired);
    checks++;
    if (expired) begin
      errors++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    end
  endtask

  task automatic model_update(input bit rd, input logic [31:0] rdpc, input bit rv,
                              input logic [31:0] rdata, input bit acc, input bit pop);
    flight_t f;
    bit push;
    word_t w;
    if (m_phase == 0) begin
      m_phase = 1;
      if (rd) m_pc = rdpc & 32'hFFFF_FFFC;
      return;
    end
    push = 1'b0;
    if (rv && m_fl.size() > 0) begin
      f = m_fl.pop_front();
      if (!f.stale && !rd) begin
        push = 1'b1;
        w = '{f.pc, rdata};
      end
    end
    if (rd) begin
      m_fifo.delete();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      if (acc) m_fl.push_back('{m_pc, 1'b1});
      m_pc = rdpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
        chk("fifo_no_overflow", 32'(m_fifo.size() < DEPTH), 32'd1);
        m_fifo.push_back(w);
      end
      if (acc) begin
        m_fl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Called at a falling edge; drives inputs, checks outputs, advances model across the rising edge.
  task automatic do_cycle();
    bit e_rv, e_iv, rd, rv, real_rsp, acc_dut;
    logic [31:0] rdpc, rdata, addr_dut;
    int due;
    imem_req_ready = (int'($urandom_range(99)) < p_ready);
    instr_ready    = (int'($urandom_range(99)) < p_iready);
    rd   = force_rd || (int'($urandom_range(999)) < p_redirect);
    rdpc = force_rd ? force_pc : $urandom();
    force_rd = 1'b0;
    redirect = rd;
    redirect_pc = rdpc;
    real_rsp = (mem_q.size() > 0) && (mem_q[0].due == cyc);
    rv = real_rsp || spur;
    rdata = real_rsp ? memfn(mem_q[0].addr) : $urandom();
    spur = 1'b0;
    imem_rsp_valid = rv;
    imem_rsp_data  = rdata;
    #1;
    e_rv = exp_req_valid();
    e_iv = (m_fifo.size() > 0);
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(e_iv));
    if (e_iv) begin
      chk("instr_pc", instr_pc, m_fifo[0].pc);
      chk("instr", instr, m_fifo[0].data);
    end
    o_rv = imem_req_valid; o_ra = imem_req_addr; o_iv = instr_valid;
    o_ipc = instr_pc; o_instr = instr;
    acc_dut = imem_req_valid && imem_req_ready;
    o_acc = acc_dut;
    addr_dut = imem_req_addr;
    @(posedge clk);
    if (real_rsp) void'(mem_q.pop_front());
    if (acc_dut) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{addr_dut, due});
      last_due = due;
    end
    model_update(rd, rdpc, rv, rdata, e_rv && imem_req_ready, e_iv && instr_ready);
    cyc++;
    @(negedge clk);
  endtask

  // Called at a falling edge; reset is asserted mid-cycle to exercise the asynchronous path.
  task automatic apply_reset(input int ncyc);
    redirect = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0; imem_rsp_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_flushes", 32'(perf_flushes), 32'h0);
`endif
    m_fifo.delete(); m_fl.delete(); mem_q.delete();
    m_pc = RESET_PC; m_phase = 0; last_due = cyc;
    repeat (ncyc) begin
      @(negedge clk);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom();
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    rst_n = 1'b1;
    spur = 1'b1;
  endtask

  bit obs_rv[8], obs_iv[8];
  logic [31:0] obs_ra[8], obs_ipc[8];
  logic [31:0] acc_addr[2];
  int n, nacc;

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; instr_ready = 1'b0;
    checks = 0; errors = 0; cyc = 0; last_due = -1; force_rd = 1'b0; spur = 1'b0; force_pc = 32'h0;
    lat = 1; p_ready = 100; p_iready = 100; p_redirect = 0;
    m_pc = RESET_PC; m_phase = 0;
    @(negedge clk);
    apply_reset(3);

    // Startup with 1-cycle memory: IDLE, request 0x0, request 0x4, then words 0x0, 0x4 reach decode.
    for (int i = 0; i < 8; i++) begin
      do_cycle();
      obs_rv[i] = o_rv; obs_ra[i] = o_ra; obs_iv[i] = o_iv; obs_ipc[i] = o_ipc;
    end
    chk("start_idle_no_req", 32'(obs_rv[0]), 32'd0);
    chk("start_req1_valid", 32'(obs_rv[1]), 32'd1);
    chk("start_req1_addr", obs_ra[1], 32'h0);
    chk("start_req2_addr", obs_ra[2], 32'h4);
    chk("start_no_instr_c2", 32'(obs_iv[2]), 32'd0);
    chk("start_instr_c3", 32'(obs_iv[3]), 32'd1);
    chk("start_pc_c3", obs_ipc[3], 32'h0);
    chk("start_pc_c4", obs_ipc[4], 32'h4);

    // Decode stalled for 10 cycles: FIFO fills to DEPTH and requests stop.
    p_iready = 0;
    repeat (10) do_cycle();
    p_iready = 100;
    do_cycle();
    chk("stall_full_no_req", 32'(o_rv), 32'd0);
    chk("stall_head_valid", 32'(o_iv), 32'd1);
    do_cycle();
    chk("stall_second_valid", 32'(o_iv), 32'd1);
    do_cycle();
    chk("stall_drained", 32'(o_iv), 32'd0);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    n = 0;
    while (!(m_fl.size() == 2 && m_fifo.size() == 0 && !any_stale()) && n < 50) begin do_cycle(); n++; end
    bound_chk("wait_two_inflight", n >= 50);
    force_rd = 1'b1; force_pc = 32'h0000_0103;
    do_cycle();
    do_cycle();
    chk("flush_no_req", 32'(o_rv), 32'd0);
    n = 0;
    while (!o_iv && n < 40) begin do_cycle(); n++; end
    bound_chk("wait_after_flush", n >= 40);
    chk("flush_target_pc", o_ipc, 32'h0000_0100);

    // Redirect coincident with an accept and a response.
    lat = 1;
    n = 0;
    while (!(exp_req_valid() && mem_q.size() > 0 && mem_q[0].due == cyc) && n < 50) begin do_cycle(); n++; end
    bound_chk("wait_coincident", n >= 50);
    force_rd = 1'b1; force_pc = 32'h0000_0200;
    do_cycle();
    n = 0;
    while (!o_iv && n < 40) begin do_cycle(); n++; end
    bound_chk("wait_coincident_out", n >= 40);
    chk("coincident_pc", o_ipc, 32'h0000_0200);
    chk("coincident_instr", o_instr, memfn(32'h0000_0200));

    // Address wrap at the top of the space.
    force_rd = 1'b1; force_pc = 32'hFFFF_FFFE;
    do_cycle();
    nacc = 0; n = 0;
    while (nacc < 2 && n < 40) begin
      do_cycle();
      if (o_acc) begin acc_addr[nacc] = o_ra; nacc++; end
      n++;
    end
    bound_chk("wait_wrap", nacc < 2);
    if (nacc == 2) begin
      chk("wrap_first", acc_addr[0], 32'hFFFF_FFFC);
      chk("wrap_second", acc_addr[1], 32'h0000_0000);
    end

    // Randomized segments.
    for (int s = 0; s < 6; s++) begin
      lat = $urandom_range(1, 4);
      p_ready = $urandom_range(30, 100);
      p_iready = $urandom_range(20, 100);
      p_redirect = $urandom_range(5, 80);
      repeat (500) do_cycle();
    end

    // Reset mid-stream with the FIFO full.
    lat = 1; p_ready = 100; p_iready = 0; p_redirect = 0;
    n = 0;
    while (!(m_fifo.size() == DEPTH && !any_stale()) && n < 60) begin do_cycle(); n++; end
    bound_chk("wait_full_before_reset", n >= 60);
    chk("prereset_instr_valid", 32'(instr_valid), 32'd1);
    apply_reset(2);
    p_iready = 100;
    for (int i = 0; i < 8; i++) begin
      do_cycle();
      obs_rv[i] = o_rv; obs_ra[i] = o_ra; obs_iv[i] = o_iv; obs_ipc[i] = o_ipc;
    end
    chk("restart_req_addr", obs_ra[1], RESET_PC);
    chk("restart_req_valid", 32'(obs_rv[1]), 32'd1);
    chk("restart_first_pc", obs_ipc[3], RESET_PC);

    p_ready = 70; p_iready = 70; p_redirect = 30; lat = 2;
    repeat (300) do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
